// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage type enums (ALU and multiply/divide) plus muldiv op-decode helpers.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of restoring division or shift-add multiplication on unsigned magnitudes.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shf,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shf
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_addend;

    always_comb begin
        w_addend = i_shf[0] ? i_dvs : '0;
        w_trial  = {i_acc, i_shf[WIDTH-1]} - {1'b0, i_dvs};
        w_sum    = {1'b0, i_acc} + {1'b0, w_addend};
        o_acc    = '0;
        o_shf    = '0;
        if (i_is_div) begin
            // Borrow out of the trial subtract means the divisor did not fit: restore.
            if (!w_trial[WIDTH]) begin
                o_acc = w_trial[WIDTH-1:0];
                o_shf = {i_shf[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[WIDTH-2:0], i_shf[WIDTH-1]};
                o_shf = {i_shf[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_shf = {w_sum[0], i_shf[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit; iterative divide, multiply is single-cycle
// when MULDIV_FAST_MUL_EN is defined, otherwise iterative on the shared step datapath.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t    r_state;
    muldiv_op_t       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_shf, r_dvs, r_out;
    logic             r_neg, r_out_valid;

    logic             w_is_div, w_a_neg, w_b_neg, w_neg, w_imm, w_ovf;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_imm_res, w_res;
    logic [WIDTH-1:0] w_acc_nx, w_shf_nx, w_quo, w_rem;
    logic [PW-1:0]    w_prod, w_prod_fix;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out       = r_out;
    assign out_valid = r_out_valid;

    // Operand decode: signs, magnitudes and result sign on accept.
    assign w_is_div = op_is_div(op);
    assign w_a_neg  = op_a_signed(op) & opA[WIDTH-1];
    assign w_b_neg  = op_b_signed(op) & opB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -opA : opA;
    assign w_b_mag  = w_b_neg ? -opB : opB;
    assign w_neg    = (op == REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_ovf    = (op inside {DIV, REM}) && (opA == MIN_NEG) && (opB == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [PW-1:0] w_fa, w_fb;
    logic        [PW-1:0] w_fprod;
    // Extending past WIDTH+1 bits leaves the low 2*WIDTH product bits unchanged.
    assign w_fa    = {{WIDTH{op_a_signed(op) & opA[WIDTH-1]}}, opA};
    assign w_fb    = {{WIDTH{op_b_signed(op) & opB[WIDTH-1]}}, opB};
    assign w_fprod = w_fa * w_fb;
`endif

    always_comb begin
        w_imm     = 1'b0;
        w_imm_res = '0;
        if (w_is_div && (opB == '0)) begin
            w_imm     = 1'b1;
            w_imm_res = (op inside {DIV, DIVU}) ? '1 : opA;
        end else if (w_ovf) begin
            w_imm     = 1'b1;
            w_imm_res = (op == DIV) ? MIN_NEG : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!w_is_div) begin
            w_imm     = 1'b1;
            w_imm_res = (op == MUL) ? w_fprod[WIDTH-1:0] : w_fprod[PW-1:WIDTH];
        end
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (op_is_div(r_op)),
        .i_acc    (r_acc),
        .i_shf    (r_shf),
        .i_dvs    (r_dvs),
        .o_acc    (w_acc_nx),
        .o_shf    (w_shf_nx)
    );

    // Sign fix-up applied to the outcome of the final step.
    always_comb begin
        w_prod     = {w_acc_nx, w_shf_nx};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        w_quo      = r_neg ? -w_shf_nx : w_shf_nx;
        w_rem      = r_neg ? -w_acc_nx : w_acc_nx;
        case (r_op)
            MUL:                 w_res = w_prod_fix[WIDTH-1:0];
            MULH, MULHSU, MULHU: w_res = w_prod_fix[PW-1:WIDTH];
            DIV, DIVU:           w_res = w_quo;
            default:             w_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= MUL;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_shf       <= '0;
            r_dvs       <= '0;
            r_neg       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op <= op;
                    if (w_imm) begin
                        r_out       <= w_imm_res;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        // Divide shifts the dividend out; multiply shifts the multiplier out.
                        r_acc   <= '0;
                        r_shf   <= w_is_div ? w_a_mag : w_b_mag;
                        r_dvs   <= w_is_div ? w_b_mag : w_a_mag;
                        r_neg   <= w_neg;
                        r_cnt   <= CW'(WIDTH);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nx;
                    r_shf <= w_shf_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out       <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH = 32 (honours MULDIV_FAST_MUL_EN).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int unsigned WIDTH = 32;
    // Latency counted as clock edges after the accepting edge until out_valid is seen.
    localparam int LAT_IMM  = 0;
    localparam int LAT_ITER = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = LAT_IMM;
`else
    localparam int LAT_MUL = LAT_ITER;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    muldiv_op_t       op;
    logic [WIDTH-1:0] opA, opB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency, check result, hold in DONE for 'hold' cycles, retire.
    task automatic do_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input int hold);
        int n;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        op = o; opA = a; opB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".lat"}, 32'(n), 32'(lat));
        check({tag, ".out"}, out, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_out"}, out, exp);
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".retire_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".retire_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = MUL; opA = '0; opB = '0;
        #2;
        check("rst.out", out, 32'h0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("mul",    MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL, 0);
        do_op("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL, 0);
        do_op("mulh",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL, 0);
        do_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL, 0);
        do_op("div",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_ITER, 0);
        do_op("rem",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_ITER, 0);
        do_op("divu",   DIVU,   32'd100,      32'd7,        32'd14,       LAT_ITER, 0);
        do_op("remu",   REMU,   32'd100,      32'd7,        32'd2,        LAT_ITER, 0);
        do_op("divu0",  DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_IMM, 0);
        do_op("remu0",  REMU,   32'd5,        32'd0,        32'd5,        LAT_IMM, 0);
        do_op("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_IMM, 0);
        do_op("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        LAT_IMM, 0);
        do_op("bp",     DIVU,   32'd1000,     32'd3,        32'd333,      LAT_ITER, 10);

        // Abort a divide ten cycles in; out keeps the last retired result.
        op = DIV; opA = 32'd1000; opB = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("flush.pre_valid", 32'(out_valid), 32'd0);
        check("flush.pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.in_ready", 32'(in_ready), 32'd1);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.out_hold", out, 32'd333);
        do_op("postflush", MUL, 32'd6, 32'd7, 32'd42, LAT_MUL, 0);

        // Asynchronous reset in the middle of an iterative divide.
        op = DIVU; opA = 32'd1000; opB = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("arst.out", out, 32'h0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        do_op("postrst", DIVU, 32'd9, 32'd3, 32'd3, LAT_ITER, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
